pc_ctrl: RTL and testbench

Fetch-stage sequencer that owns the program counter of the pipelined MIPS core. It accepts redirect requests (jal/jr/beq) from the D stage, the stall from the hazard unit, and the ready handshake of a multi-cycle instruction memory, and decides each cycle whether and where the PC advances. It also buffers a redirect that arrives while the fetch is blocked, and normalizes every next PC into the 64 KiB instruction window starting at 0x3000.

---
 rtl/pc_ctrl_pkg.sv | 19 +
 rtl/pc_wrap.sv | 17 +
 rtl/pc_ctrl.sv | 124 ++++++++++++
 tb/tb_pc_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings and defaults for the fetch-stage PC sequencer.
// Holds redirect kinds, sequencer states and the instruction-window defaults.
package pc_ctrl_pkg;

    localparam logic [1:0] KIND_BEQ = 2'b00;
    localparam logic [1:0] KIND_JAL = 2'b01;
    localparam logic [1:0] KIND_JR  = 2'b10;
    localparam logic [1:0] KIND_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_PC_SPAN  = 32'h0001_0000;

endpackage

// File: rtl/pc_wrap.sv
// Folds any 32-bit address into the window [BASE, BASE+SPAN); SPAN must be a power of two.
// Latency: combinational. Backpressure: none.
module pc_wrap #(
    parameter logic [31:0] BASE = 32'h0000_3000,
    parameter logic [31:0] SPAN = 32'h0001_0000
) (
    input  logic [31:0] x_in,
    output logic [31:0] x_out
);

    localparam logic [31:0] MASK = SPAN - 32'd1;

    always_comb begin
        x_out = ((x_in - BASE) & MASK) + BASE;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: advances pc on fetch completion, applies or buffers redirects.
// Latency: pc/f_valid update 1 cycle after the completing edge. Backpressure: stall freezes, im_ready=0 waits.
// Define PC_CTRL_WRAP_EN to fold every loaded pc into the instruction window.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_SPAN  = DEF_PC_SPAN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        im_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic        jump_judge,
    input  logic [31:0] jal32,
    input  logic [31:0] jr32,
    input  logic [31:0] beq32,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        im_req,
    output logic        f_valid,
    output logic        pend_valid,
    output logic        err,
    output logic [15:0] redir_cnt
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        err_q, err_d;
    logic [15:0] redir_cnt_q, redir_cnt_d;

    logic        complete;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

`ifdef PC_CTRL_WRAP_EN
    pc_wrap #(
        .BASE (RESET_PC),
        .SPAN (PC_SPAN)
    ) u_pc_wrap (
        .x_in  (next_pc_raw),
        .x_out (next_pc)
    );
`else
    assign next_pc = next_pc_raw;
`endif

    always_comb begin
        complete = im_ready & ~stall;
        taken    = 1'b0;
        target   = beq32;
        if (redir_valid) begin
            case (redir_kind)
                KIND_JAL: begin taken = 1'b1;       target = jal32; end
                KIND_JR:  begin taken = 1'b1;       target = jr32;  end
                KIND_BEQ: begin taken = jump_judge; target = beq32; end
                default:  begin taken = 1'b0;       target = beq32; end
            endcase
        end

        // A buffered redirect always wins: D is frozen, so any live redirect is the same instruction.
        if (pend_valid_q)   next_pc_raw = pend_target_q;
        else if (taken)     next_pc_raw = target;
        else                next_pc_raw = pc_q + 32'd4;

        pc_d          = pc_q;
        f_valid_d     = complete;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        err_d         = err_q | (redir_valid & (redir_kind == KIND_ILL));
        redir_cnt_d   = redir_cnt_q;

        if (complete) begin
            pc_d         = next_pc;
            pend_valid_d = 1'b0;
            if ((pend_valid_q | taken) && (redir_cnt_q != 16'hFFFF))
                redir_cnt_d = redir_cnt_q + 16'd1;
        end else if (taken && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = target;
        end

        if (stall)                  state_d = S_HOLD;
        else if (state_q == S_HOLD) state_d = S_RUN;
        else if (!im_ready)         state_d = S_WAIT;
        else                        state_d = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            f_valid_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            err_q         <= 1'b0;
            redir_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            f_valid_q     <= f_valid_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            err_q         <= err_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign im_req     = (state_q != S_HOLD);
    assign f_valid    = f_valid_q;
    assign pend_valid = pend_valid_q;
    assign err        = err_q;
    assign redir_cnt  = redir_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed test-plan steps followed by random traffic vs. a queue-based model.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, im_ready, redir_valid, jump_judge;
    logic [1:0]  redir_kind;
    logic [31:0] jal32, jr32, beq32;
    logic [31:0] pc, pc_plus4;
    logic        im_req, f_valid, pend_valid, err;
    logic [15:0] redir_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    int          m_cnt;
    bit          m_err, m_fval, m_prev_stall;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .im_ready(im_ready),
        .redir_valid(redir_valid), .redir_kind(redir_kind), .jump_judge(jump_judge),
        .jal32(jal32), .jr32(jr32), .beq32(beq32),
        .pc(pc), .pc_plus4(pc_plus4), .im_req(im_req), .f_valid(f_valid),
        .pend_valid(pend_valid), .err(err), .redir_cnt(redir_cnt)
    );

    function automatic logic [31:0] norm(input logic [31:0] x);
`ifdef PC_CTRL_WRAP_EN
        return ((x - 32'h3000) % 32'h1_0000) + 32'h3000;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit          done, take;
        logic [31:0] tgt, npc;
        if (reset) begin
            m_pc = 32'h3000; m_pend.delete(); m_cnt = 0;
            m_err = 0; m_fval = 0; m_prev_stall = 0;
            return;
        end
        done = im_ready && !stall;
        take = redir_valid && (redir_kind == 2'd1 || redir_kind == 2'd2 ||
                               (redir_kind == 2'd0 && jump_judge));
        tgt  = (redir_kind == 2'd1) ? jal32 : (redir_kind == 2'd2) ? jr32 : beq32;
        if (redir_valid && redir_kind == 2'd3) m_err = 1;
        if (done) begin
            if (m_pend.size() != 0) begin
                npc = m_pend.pop_front();
                if (m_cnt < 65535) m_cnt++;
            end else if (take) begin
                npc = tgt;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                npc = m_pc + 4;
            end
            m_pc = norm(npc);
        end else if (take && m_pend.size() == 0) begin
            m_pend.push_back(tgt);
        end
        m_fval = done;
        m_prev_stall = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("im_req", {31'd0, im_req}, {31'd0, !m_prev_stall});
        chk("f_valid", {31'd0, f_valid}, {31'd0, m_fval});
        chk("pend_valid", {31'd0, pend_valid}, {31'd0, m_pend.size() != 0});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("redir_cnt", {16'd0, redir_cnt}, 32'(m_cnt));
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'h3000 + {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
            2:       return {$urandom_range(0, 32'h3_0000)} & 32'hFFFF_FFFC;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1; stall = 0; im_ready = 0; redir_valid = 0; redir_kind = 0;
        jump_judge = 0; jal32 = 0; jr32 = 0; beq32 = 0;
        tick();
        chk("reset_pc", pc, 32'h3000);
        chk("reset_im_req", {31'd0, im_req}, 32'd1);

        // Sequential fetch
        reset = 0; im_ready = 1;
        tick(); chk("seq_pc1", pc, 32'h3004); chk("seq_fv", {31'd0, f_valid}, 32'd1);
        tick(); chk("seq_pc2", pc, 32'h3008);
        tick(); tick(); chk("seq_pc4", pc, 32'h3010);

        // jal
        redir_valid = 1; redir_kind = 2'd1; jal32 = 32'h3100;
        tick(); chk("jal_pc", pc, 32'h3100); chk("jal_cnt", {16'd0, redir_cnt}, 32'd1);

        // beq not taken, then taken
        redir_kind = 2'd0; jump_judge = 0; beq32 = 32'h3200;
        tick(); chk("beq_nt_pc", pc, 32'h3104); chk("beq_nt_cnt", {16'd0, redir_cnt}, 32'd1);
        jump_judge = 1;
        tick(); chk("beq_t_pc", pc, 32'h3200); chk("beq_t_cnt", {16'd0, redir_cnt}, 32'd2);

        // jr while memory is busy -> buffered
        redir_kind = 2'd2; jr32 = 32'h4000; im_ready = 0;
        tick(); chk("jr_pend1", {31'd0, pend_valid}, 32'd1); chk("jr_req1", {31'd0, im_req}, 32'd1);
        tick(); chk("jr_pend2", {31'd0, pend_valid}, 32'd1); chk("jr_pc_hold", pc, 32'h3200);
        im_ready = 1;
        tick(); chk("jr_pc", pc, 32'h4000); chk("jr_pend0", {31'd0, pend_valid}, 32'd0);
        chk("jr_cnt", {16'd0, redir_cnt}, 32'd3);

        // Out-of-window targets
        jr32 = 32'h0001_3000;
        tick();
`ifdef PC_CTRL_WRAP_EN
        chk("wrap_hi", pc, 32'h3000);
`else
        chk("nowrap_hi", pc, 32'h0001_3000);
`endif
        redir_kind = 2'd1; jal32 = 32'h0000_2FFC;
        tick();
`ifdef PC_CTRL_WRAP_EN
        chk("wrap_lo", pc, 32'h0001_2FFC);
`else
        chk("nowrap_lo", pc, 32'h0000_2FFC);
`endif

        // Illegal kind
        redir_kind = 2'd3;
        tick(); chk("ill_pc", pc, m_pc); chk("ill_err", {31'd0, err}, 32'd1);
        redir_valid = 0;
        tick(); chk("ill_err_sticky", {31'd0, err}, 32'd1);

        // stall with im_ready: word dropped
        stall = 1;
        tick(); chk("stall_fv", {31'd0, f_valid}, 32'd0); chk("stall_req", {31'd0, im_req}, 32'd0);
        tick();
        stall = 0;
        tick();

        // Reset during WAIT with a pending redirect
        im_ready = 0; redir_valid = 1; redir_kind = 2'd2; jr32 = 32'h5000;
        tick(); chk("rst_pre_pend", {31'd0, pend_valid}, 32'd1);
        reset = 1;
        tick();
        chk("rst_pc", pc, 32'h3000); chk("rst_pend", {31'd0, pend_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0); chk("rst_cnt", {16'd0, redir_cnt}, 32'd0);
        reset = 0; redir_valid = 0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            im_ready    = ($urandom_range(0, 9) < 7);
            redir_valid = ($urandom_range(0, 2) == 0);
            redir_kind  = 2'($urandom_range(0, 3));
            jump_judge  = 1'($urandom_range(0, 1));
            jal32       = rnd_addr();
            jr32        = rnd_addr();
            beq32       = rnd_addr();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
